// File: rtl/program_sequencer_pkg.sv
// program_sequencer_pkg
// Shared definitions for the 8-bit processor's program sequencer:
//   - instruction field bit positions (16-bit instruction word)
//   - opcode constants
//   - write-back source select codes
//   - sequencer state encoding
// Instruction format: [15:12] opcode, [11:8] destination register,
//                     [7:4] read port A, [3:0] read port B, [7:0] immediate.
package program_sequencer_pkg;

    // Instruction field positions
    localparam int unsigned OP_MSB  = 15;
    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned RA_MSB  = 7;
    localparam int unsigned RA_LSB  = 4;
    localparam int unsigned RB_MSB  = 3;
    localparam int unsigned RB_LSB  = 0;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;

    // Opcodes
    localparam logic [3:0] OP_SETC  = 4'b0000;  // write immediate
    localparam logic [3:0] OP_LOAD  = 4'b0001;  // write external input
    localparam logic [3:0] OP_COPY  = 4'b0010;  // copy port A
    localparam logic [3:0] OP_CCOPY = 4'b0011;  // copy port A if port B != 0
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_NEG   = 4'b0101;
    localparam logic [3:0] OP_AND   = 4'b0110;
    localparam logic [3:0] OP_OR    = 4'b0111;
    localparam logic [3:0] OP_SHL   = 4'b1000;
    localparam logic [3:0] OP_CMP   = 4'b1011;
    localparam logic [3:0] OP_JMP   = 4'b1101;
    localparam logic [3:0] OP_HALT  = 4'b1110;
    localparam logic [3:0] OP_CHALT = 4'b1111;  // halt if port B == 0

    // Write-back source select
    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_IMM   = 2'd1;
    localparam logic [1:0] WB_EXT   = 2'd2;
    localparam logic [1:0] WB_PORTA = 2'd3;

    // Sequencer states
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StFetch   = 2'd1,
        StExecute = 2'd2,
        StHalted  = 2'd3
    } state_e;

    // Extract the opcode field from an instruction word
    function automatic logic [3:0] ir_opcode(input logic [15:0] ir);
        return ir[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// program_sequencer_if
// Bundles the sequencer's control/status, instruction memory and register-file
// signals. Clock and reset stay outside as plain ports.
//   master : the sequencer (drives memory address, register-file controls, status)
//   slave  : the surrounding datapath / board (drives start, switches, memory data,
//            port B data)
interface program_sequencer_if;

    // Run control
    logic        start;
    logic [7:0]  programSelect;

    // Instruction memory
    logic [7:0]  imem_address;
    logic [7:0]  imem_select;
    logic [15:0] instruction;

    // Register file / ALU controls
    logic [3:0]  rf_read_a;
    logic [3:0]  rf_read_b;
    logic [7:0]  rf_read_b_data;
    logic        rf_write_en;
    logic [3:0]  rf_write_addr;
    logic [1:0]  wb_sel;
    logic [3:0]  alu_op;
    logic [7:0]  immediate;

    // Status
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        fault;
    logic        illegal;
    logic [15:0] instr_count;

    modport master (
        input  start, programSelect, instruction, rf_read_b_data,
        output imem_address, imem_select,
        output rf_read_a, rf_read_b, rf_write_en, rf_write_addr, wb_sel, alu_op, immediate,
        output pc, busy, halted, fault, illegal, instr_count
    );

    modport slave (
        output start, programSelect, instruction, rf_read_b_data,
        input  imem_address, imem_select,
        input  rf_read_a, rf_read_b, rf_write_en, rf_write_addr, wb_sel, alu_op, immediate,
        input  pc, busy, halted, fault, illegal, instr_count
    );

endinterface

// File: rtl/program_sequencer_instruction_decoder.sv
// program_sequencer_instruction_decoder
// Purely combinational decode of the latched instruction register.
// Ports:
//   ir          in  16  latched instruction
//   b_data      in   8  register-file port B data (conditional ops)
//   write_en    out  1  instruction writes the destination register
//   wb_sel      out  2  write-back source
//   is_jump     out  1  unconditional jump to the immediate
//   is_halt     out  1  halt (or conditional halt whose condition holds)
//   is_illegal  out  1  unused opcode
module program_sequencer_instruction_decoder
    import program_sequencer_pkg::*;
(
    input  logic [15:0] ir,
    input  logic [7:0]  b_data,
    output logic        write_en,
    output logic [1:0]  wb_sel,
    output logic        is_jump,
    output logic        is_halt,
    output logic        is_illegal
);

    logic [3:0] opcode;
    logic       b_zero;
    logic       unused_ir;

    assign opcode    = ir_opcode(ir);
    assign b_zero    = (b_data == 8'd0);
    // Only the opcode matters here; the operand fields are routed by the top.
    assign unused_ir = ^ir[RD_MSB:0];

    always_comb begin
        write_en   = 1'b0;
        wb_sel     = WB_ALU;
        is_jump    = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_SETC: begin
                write_en = 1'b1;
                wb_sel   = WB_IMM;
            end
            OP_LOAD: begin
                write_en = 1'b1;
                wb_sel   = WB_EXT;
            end
            OP_COPY: begin
                write_en = 1'b1;
                wb_sel   = WB_PORTA;
            end
            OP_CCOPY: begin
                write_en = !b_zero;
                wb_sel   = WB_PORTA;
            end
            OP_ADD, OP_NEG, OP_AND, OP_OR, OP_SHL, OP_CMP: begin
                write_en = 1'b1;
                wb_sel   = WB_ALU;
            end
            OP_JMP:   is_jump = 1'b1;
            OP_HALT:  is_halt = 1'b1;
            OP_CHALT: is_halt = b_zero;
            default:  is_illegal = 1'b1;  // 1001, 1010, 1100
        endcase
    end

endmodule

// File: rtl/program_sequencer.sv
// program_sequencer
// Fetch/execute control unit for the 8-bit processor. Each instruction takes
// two cycles: FETCH latches the instruction addressed by pc, EXECUTE decodes it,
// strobes the register-file write, and picks the next pc or a halt.
// Parameters:
//   MEM_DEPTH  valid instruction addresses per program (pc in 0..MEM_DEPTH-1)
//   MAX_INSTR  executed-instruction limit before a watchdog fault halt
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous, active-high
//   bus    master modport of program_sequencer_if (memory, register file, status)
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 128,
    parameter int unsigned MAX_INSTR = 4096
) (
    input  logic                clk,
    input  logic                reset,
    program_sequencer_if.master bus
);

    // MEM_DEPTH may be 256, so pc bounds are compared at 9 bits.
    localparam logic [8:0]  PC_LIMIT    = 9'(MEM_DEPTH);
    localparam logic [15:0] COUNT_LIMIT = 16'(MAX_INSTR);

    state_e      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q;
    logic [7:0]  sel_q, sel_d;
    logic [15:0] count_q, count_d;
    logic        fault_q, fault_d;
    logic        illegal_q, illegal_d;

    logic        dec_write_en;
    logic [1:0]  dec_wb_sel;
    logic        dec_is_jump;
    logic        dec_is_halt;
    logic        dec_is_illegal;

    logic [8:0]  pc_inc;
    logic [8:0]  next_pc;
    logic [15:0] count_inc;

    program_sequencer_instruction_decoder u_instruction_decoder (
        .ir         (ir_q),
        .b_data     (bus.rf_read_b_data),
        .write_en   (dec_write_en),
        .wb_sel     (dec_wb_sel),
        .is_jump    (dec_is_jump),
        .is_halt    (dec_is_halt),
        .is_illegal (dec_is_illegal)
    );

    assign pc_inc    = {1'b0, pc_q} + 9'd1;
    assign next_pc   = dec_is_jump ? {1'b0, ir_q[IMM_MSB:IMM_LSB]} : pc_inc;
    assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        sel_d     = sel_q;
        count_d   = count_q;
        fault_d   = fault_q;
        illegal_d = illegal_q;
        unique case (state_q)
            StIdle, StHalted: begin
                if (bus.start) begin
                    state_d   = StFetch;
                    sel_d     = bus.programSelect;
                    pc_d      = 8'd0;
                    count_d   = 16'd0;
                    fault_d   = 1'b0;
                    illegal_d = 1'b0;
                end
            end
            StFetch: begin
                state_d = StExecute;
            end
            StExecute: begin
                count_d = count_inc;
                if (dec_is_illegal) begin
                    illegal_d = 1'b1;
                end
                // Halt beats watchdog beats address fault; on any stop pc keeps
                // the address of the instruction just executed.
                if (dec_is_halt) begin
                    state_d = StHalted;
                end else if (count_inc == COUNT_LIMIT) begin
                    fault_d = 1'b1;
                    state_d = StHalted;
                end else if (next_pc >= PC_LIMIT) begin
                    fault_d = 1'b1;
                    state_d = StHalted;
                end else begin
                    pc_d    = next_pc[7:0];
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            pc_q      <= 8'd0;
            ir_q      <= 16'd0;
            sel_q     <= 8'd0;
            count_q   <= 16'd0;
            fault_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            sel_q     <= sel_d;
            count_q   <= count_d;
            fault_q   <= fault_d;
            illegal_q <= illegal_d;
            if (state_q == StFetch) begin
                ir_q <= bus.instruction;
            end
        end
    end

    // Outputs
    always_comb begin
        bus.imem_address  = pc_q;
        bus.imem_select   = sel_q;
        bus.rf_read_a     = ir_q[RA_MSB:RA_LSB];
        bus.rf_read_b     = ir_q[RB_MSB:RB_LSB];
        bus.rf_write_addr = ir_q[RD_MSB:RD_LSB];
        bus.alu_op        = ir_q[OP_MSB:OP_LSB];
        bus.immediate     = ir_q[IMM_MSB:IMM_LSB];
        // IR resets to 0000 (write immediate), whose decode would give wb_sel=1;
        // hold it at 0 until the first run so every output is 0 out of reset.
        bus.wb_sel        = (state_q == StIdle) ? WB_ALU : dec_wb_sel;
        bus.rf_write_en   = (state_q == StExecute) && dec_write_en;
        bus.pc            = pc_q;
        bus.busy          = (state_q == StFetch) || (state_q == StExecute);
        bus.halted        = (state_q == StHalted);
        bus.fault         = fault_q;
        bus.illegal       = illegal_q;
        bus.instr_count   = count_q;
    end

endmodule

// File: tb/tb_program_sequencer.sv
module tb_program_sequencer;
    import program_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    program_sequencer_if bus ();
    program_sequencer_if bus2 ();

    // Main DUT: short watchdog so runaway loops stop quickly.
    program_sequencer #(.MEM_DEPTH(128), .MAX_INSTR(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Small-memory DUT for the pc-overrun fault.
    program_sequencer #(.MEM_DEPTH(8), .MAX_INSTR(4096)) dut_small (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.master)
    );

    logic [15:0] mem [0:255];
    assign bus.instruction  = mem[bus.imem_address];
    assign bus2.instruction = mem[bus2.imem_address];

    int checks = 0;
    int errors = 0;

    // Scoreboard of expected write strobes:
    // {alu_op, rf_write_addr, wb_sel, rf_read_a, rf_read_b, immediate}
    logic [25:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [25:0] rec(input logic [15:0] w, input logic [1:0] wb);
        return {w[15:12], w[11:8], wb, w[7:4], w[3:0], w[7:0]};
    endfunction

    // Every write strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (!reset && bus.rf_write_en) begin
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("write_fields",
                      32'({bus.alu_op, bus.rf_write_addr, bus.wb_sel, bus.rf_read_a,
                           bus.rf_read_b, bus.immediate}),
                      32'(exp_q.pop_front()));
            end
        end
    end

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
    endtask

    task automatic start_run(input logic [7:0] sel);
        @(negedge clk);
        bus.programSelect = sel;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_halt(input int budget, output int cycles);
        cycles = 0;
        while (!bus.halted && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check("halt_reached", 32'(bus.halted), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          cyc;
        logic [15:0] w;
        logic [3:0]  ops [7];

        reset = 1'b1;
        bus.start = 1'b0;
        bus.programSelect = 8'd0;
        bus.rf_read_b_data = 8'd0;
        bus2.start = 1'b0;
        bus2.programSelect = 8'd0;
        bus2.rf_read_b_data = 8'd0;
        fill_halt();

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs",
              32'(|{bus.imem_address, bus.imem_select, bus.rf_read_a, bus.rf_read_b,
                    bus.rf_write_en, bus.rf_write_addr, bus.wb_sel, bus.alu_op,
                    bus.immediate, bus.pc, bus.busy, bus.halted, bus.fault,
                    bus.illegal, bus.instr_count}), 32'd0);
        reset = 1'b0;

        // Basic program: write immediate, six copies, halt at 7
        fill_halt();
        mem[0] = 16'h0102;
        exp_q.push_back(rec(mem[0], WB_IMM));
        for (int i = 1; i < 7; i++) begin
            w = {4'h2, 4'(i), 8'h34};
            mem[i] = w;
            exp_q.push_back(rec(w, WB_PORTA));
        end
        mem[7] = 16'hE000;
        start_run(8'h04);
        @(negedge clk);
        check("t2_c2_we", 32'(bus.rf_write_en), 32'd1);
        check("t2_c2_addr", 32'(bus.rf_write_addr), 32'd1);
        check("t2_c2_wbsel", 32'(bus.wb_sel), 32'd1);
        check("t2_c2_imm", 32'(bus.immediate), 32'd2);
        wait_halt(40, cyc);
        check("t2_cycles", 32'(cyc), 32'd15);
        check("t2_count", 32'(bus.instr_count), 32'd8);
        check("t2_fault", 32'(bus.fault), 32'd0);
        check("t2_pc", 32'(bus.pc), 32'd7);
        check("t2_select", 32'(bus.imem_select), 32'h04);
        check("t2_queue", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("t2_halted_no_we", 32'(bus.rf_write_en), 32'd0);

        // Reset asserted during EXECUTE of a write
        exp_q.push_back(rec(16'h0102, WB_IMM));
        start_run(8'h04);
        @(negedge clk);
        #1;
        check("t1_pre_we", 32'(bus.rf_write_en), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("t1_we_drop", 32'(bus.rf_write_en), 32'd0);
        check("t1_outputs",
              32'(|{bus.imem_address, bus.imem_select, bus.rf_read_a, bus.rf_read_b,
                    bus.rf_write_addr, bus.wb_sel, bus.alu_op, bus.immediate, bus.pc,
                    bus.busy, bus.halted, bus.fault, bus.illegal, bus.instr_count}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("t1_idle", 32'({bus.busy, bus.halted}), 32'd0);
        check("t1_queue", 32'(exp_q.size()), 32'd0);

        // Conditional copy / conditional halt, port B zero then non-zero
        fill_halt();
        for (int i = 0; i < 5; i++) mem[i] = (i == 1) ? 16'h3422 : {4'h2, 4'(i + 2), 8'h56};
        mem[5] = 16'hF004;
        mem[6] = 16'hE000;
        bus.rf_read_b_data = 8'd0;
        for (int i = 0; i < 5; i++) if (i != 1) exp_q.push_back(rec(mem[i], WB_PORTA));
        start_run(8'h01);
        wait_halt(40, cyc);
        check("t3a_pc", 32'(bus.pc), 32'd5);
        check("t3a_count", 32'(bus.instr_count), 32'd6);
        check("t3a_queue", 32'(exp_q.size()), 32'd0);
        bus.rf_read_b_data = 8'd3;
        for (int i = 0; i < 5; i++) exp_q.push_back(rec(mem[i], WB_PORTA));
        start_run(8'h01);
        wait_halt(40, cyc);
        check("t3b_pc", 32'(bus.pc), 32'd6);
        check("t3b_count", 32'(bus.instr_count), 32'd7);
        check("t3b_queue", 32'(exp_q.size()), 32'd0);
        bus.rf_read_b_data = 8'd0;

        // ALU and external-input writes
        fill_halt();
        ops = '{OP_LOAD, OP_ADD, OP_NEG, OP_AND, OP_OR, OP_SHL, OP_CMP};
        for (int i = 0; i < 7; i++) begin
            w = {ops[i], 4'(i + 8), 4'(i), 4'(15 - i)};
            mem[i] = w;
            exp_q.push_back(rec(w, (ops[i] == OP_LOAD) ? WB_EXT : WB_ALU));
        end
        start_run(8'h02);
        wait_halt(40, cyc);
        check("alu_count", 32'(bus.instr_count), 32'd8);
        check("alu_queue", 32'(exp_q.size()), 32'd0);

        // Jumps: 0 -> 9 -> 3 (halt), then an out-of-range target
        fill_halt();
        mem[0] = 16'hD009;
        mem[9] = 16'hD003;
        mem[3] = 16'hE000;
        start_run(8'h03);
        wait_halt(40, cyc);
        check("t4_pc", 32'(bus.pc), 32'd3);
        check("t4_count", 32'(bus.instr_count), 32'd3);
        check("t4_fault", 32'(bus.fault), 32'd0);
        mem[9] = 16'hD0C8;
        start_run(8'h03);
        wait_halt(40, cyc);
        check("t4_bad_fault", 32'(bus.fault), 32'd1);
        check("t4_bad_pc", 32'(bus.pc), 32'd9);
        check("t4_bad_count", 32'(bus.instr_count), 32'd2);
        check("t4_queue", 32'(exp_q.size()), 32'd0);

        // Watchdog on a jump-to-self loop
        fill_halt();
        mem[0] = 16'hD000;
        start_run(8'h05);
        wait_halt(80, cyc);
        check("t5_cycles", 32'(cyc), 32'd32);
        check("t5_count", 32'(bus.instr_count), 32'd16);
        check("t5_fault", 32'(bus.fault), 32'd1);
        check("t5_pc", 32'(bus.pc), 32'd0);
        mem[0] = 16'hE000;
        start_run(8'h05);
        check("t5_fault_cleared", 32'(bus.fault), 32'd0);
        wait_halt(40, cyc);
        check("t5_halt_count", 32'(bus.instr_count), 32'd1);
        // Halt as the 16th instruction wins over the watchdog
        for (int i = 0; i < 15; i++) mem[i] = {8'hD0, 8'(i + 1)};
        mem[15] = 16'hE000;
        start_run(8'h05);
        wait_halt(80, cyc);
        check("t5_prio_fault", 32'(bus.fault), 32'd0);
        check("t5_prio_count", 32'(bus.instr_count), 32'd16);
        check("t5_prio_pc", 32'(bus.pc), 32'd15);

        // Illegal opcodes, start ignored while busy
        fill_halt();
        mem[0] = 16'h2112;
        mem[1] = 16'h2223;
        exp_q.push_back(rec(mem[0], WB_PORTA));
        exp_q.push_back(rec(mem[1], WB_PORTA));
        mem[2] = 16'h9000;
        mem[3] = 16'hA000;
        mem[4] = 16'hC000;
        start_run(8'h04);
        repeat (2) @(negedge clk);
        bus.programSelect = 8'hAA;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("t6_busy", 32'(bus.busy), 32'd1);
        check("t6_select_busy", 32'(bus.imem_select), 32'h04);
        wait_halt(40, cyc);
        check("t6_illegal", 32'(bus.illegal), 32'd1);
        check("t6_pc", 32'(bus.pc), 32'd5);
        check("t6_count", 32'(bus.instr_count), 32'd6);
        check("t6_fault", 32'(bus.fault), 32'd0);
        check("t6_select", 32'(bus.imem_select), 32'h04);
        check("t6_queue", 32'(exp_q.size()), 32'd0);
        mem[0] = 16'hE000;
        start_run(8'h55);
        check("t6_illegal_cleared", 32'(bus.illegal), 32'd0);
        check("t6_new_select", 32'(bus.imem_select), 32'h55);
        wait_halt(40, cyc);

        // pc overrun on the small-memory instance
        fill_halt();
        for (int i = 0; i < 8; i++) mem[i] = {4'h2, 4'(i), 8'h00};
        @(negedge clk);
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        cyc = 0;
        while (!bus2.halted && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("ovr_halted", 32'(bus2.halted), 32'd1);
        check("ovr_fault", 32'(bus2.fault), 32'd1);
        check("ovr_pc", 32'(bus2.pc), 32'd7);
        check("ovr_count", 32'(bus2.instr_count), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Fetch/execute control unit for the 8-bit processor. Drives the instruction memory address and program select.
- Latches each 16-bit instruction, decodes it, and drives register-file read/write controls and the ALU op.
- Resolves jump, halt and conditional halt.
- Sits between instructionMemory and the register file/ALU datapath. Also provides a run/halt status and a runaway-program watchdog for the board display.

Parameters:
- MEM_DEPTH, 128, number of valid instruction addresses per program. PC range is 0..MEM_DEPTH-1.
- MAX_INSTR, 4096, executed-instruction limit before a watchdog fault halt. Legal range 1..65535.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  active-high; reset is asynchronous and active-high.
- start  in  1  begin a run; sampled only in IDLE or HALTED.
- programSelect  in  8  switch inputs; captured on an accepted start.
- imem_address  out  8  instruction memory address (equals pc).
- imem_select  out  8  captured programSelect, held for the whole run.
- instruction  in  16  combinational instruction memory data.
- rf_read_a  out  4  register-file read port A address (IR[7:4]).
- rf_read_b  out  4  read port B address (IR[3:0]).
- rf_read_b_data  in  8  port B data, used for conditional ops.
- rf_write_en  out  1  register-file write strobe, one cycle.
- rf_write_addr  out  4  destination register (IR[11:8]).
- wb_sel  out  2  write-back source: 0 ALU, 1 immediate, 2 external input, 3 port A copy.
- alu_op  out  4  IR[15:12] passed to ALU.
- immediate  out  8  IR[7:0].
- pc  out  8  current program counter.
- busy  out  1  high in FETCH/EXECUTE.
- halted  out  1  high in HALTED.
- fault  out  1  sticky: PC overrun, bad jump target, or watchdog.
- illegal  out  1  sticky: unused opcode executed.
- instr_count  out  16  instructions executed this run.

Behaviour:
- **Reset values:** all outputs 0, state IDLE, IR=0, imem_select=0. Reset mid-run aborts immediately with no further write strobes.
- **States:** IDLE, FETCH, EXECUTE, HALTED.
- **Start:** in IDLE or HALTED, start=1 captures programSelect into imem_select and clears pc, instr_count, fault and illegal. Next state is FETCH. Start is ignored while busy.
- **FETCH (1 cycle):** imem_address=pc. IR<=instruction at the clock edge. Next state EXECUTE.
- **EXECUTE (1 cycle):** decode IR combinationally. rf_write_en is asserted only in this state. instr_count increments, saturating at 65535.
- **Throughput:** each instruction takes 2 cycles.
- **Opcodes:**
  - 0000 write immediate: wb_sel=1.
  - 0001 write external input: wb_sel=2.
  - 0010 copy: wb_sel=3.
  - 0011 conditional copy: wb_sel=3; write only if rf_read_b_data!=0.
  - 0100 add, 0101 negate, 0110 and, 0111 or, 1000 shift-left, 1011 compare: wb_sel=0, write.
  - 1101 jump: pc<=immediate, no write.
  - 1110 halt: go to HALTED.
  - 1111 conditional halt: HALTED if rf_read_b_data==0, else pc+1.
  - 1001, 1010, 1100: no write, illegal<=1, pc+1.
- **Next pc:** pc+1 unless jump or halt. If the next pc would be >=MEM_DEPTH, or a jump target is >=MEM_DEPTH, set fault=1 and go to HALTED. pc keeps the faulting instruction address.
- **Watchdog:** if instr_count reaches MAX_INSTR after the increment and the instruction is not itself a halt, set fault=1 and go to HALTED. The instruction's write still occurs.
- **Priority in one EXECUTE cycle:** halt > watchdog > address fault.
- **HALTED:** outputs held, rf_write_en=0. The display reads R15 externally.
- **programSelect changes mid-run:** no effect.

Decomposition:
- Shared package: opcode constants (OP_SETC, OP_LOAD, OP_COPY, OP_CCOPY, OP_ADD, OP_NEG, OP_AND, OP_OR, OP_SHL, OP_CMP, OP_JMP, OP_HALT, OP_CHALT), wb_sel codes, state encoding, field bit positions.
- One sub-module: instruction_decoder, combinational. Maps IR plus rf_read_b_data to write-enable, wb_sel, is_jump, is_halt and is_illegal.

Test Plan:
1. Reset asserted mid-EXECUTE of a write → rf_write_en drops the same cycle; all outputs 0; state IDLE; no strobe after release.
2. programSelect=8'b0000_0100, start, memory holds [0]=0000_0001_0000_0010, [7]=halt, others 0010 copies:
   - cycle 2: rf_write_en=1, rf_write_addr=1, wb_sel=1, immediate=2.
   - halted=1 after 16 cycles; instr_count=8; fault=0.
3. Conditional halt 1111_0000_0000_0100 with rf_read_b_data=0 → halted=1, pc=5. With rf_read_b_data=3 → next imem_address=6.
4. Jump 1101_0000_0000_0011 at pc=9 → next FETCH imem_address=3, no write. Jump to 0xC8 with MEM_DEPTH=128 → fault=1, halted=1, pc=9.
5. MAX_INSTR=16, [0]=jump to 0 → fault=1, halted=1 exactly after the 16th EXECUTE; instr_count=16. A subsequent start clears fault.
6. Opcode 1001 at pc=2 → illegal=1, no write, next pc=3. Start pressed while busy → ignored, imem_select unchanged.
